// File: rtl/atan_ratio_div_if.sv
// atan_ratio_div_if: sample bus into and out of the atan ratio divider
interface atan_ratio_div_if #(
   parameter int IN_W   = 16,
   parameter int FRAC_W = 8
);
   logic                     val_i;
   logic signed [IN_W-1:0]   x_i;
   logic signed [IN_W-1:0]   y_i;
   logic                     val_o;
   logic        [FRAC_W-1:0] ratio_o;
   logic        [2:0]        oct_o;
   logic                     zero_o;
   modport slave (input val_i, x_i, y_i, output val_o, ratio_o, oct_o, zero_o);
   modport master (output val_i, x_i, y_i, input val_o, ratio_o, oct_o, zero_o);
endinterface

// File: rtl/atan_ratio_div.sv
// atan_ratio_div: octant fold plus pipelined restoring divide of min/max to Q0.8.
// Define ATAN_RATIO_ROUND_EN for a guard-bit stage with round half up (latency 11 instead of 10).
module atan_ratio_div #(
   parameter int IN_W   = 16,
   parameter int FRAC_W = 8
) (
   input logic clk,
   input logic rst,
   atan_ratio_div_if.slave bus
);
`ifdef ATAN_RATIO_ROUND_EN
   localparam int STG = FRAC_W + 1;
`else
   localparam int STG = FRAC_W;
`endif
   logic [IN_W-1:0] ax, ay, num, den0;
   logic            sw;
   logic [IN_W:0]   rem  [STG];
   logic [IN_W-1:0] den  [STG];
   logic [IN_W:0]   rem2 [STG];
   logic [STG-1:0]  ge;
   logic [STG-1:0]  q    [STG+1];
   logic [3:0]      side [STG+1];
   logic [STG:0]    vld;
   logic [FRAC_W-1:0] ratio_n;
   always_comb begin
      ax   = bus.x_i[IN_W-1] ? IN_W'(-bus.x_i) : bus.x_i;
      ay   = bus.y_i[IN_W-1] ? IN_W'(-bus.y_i) : bus.y_i;
      sw   = ay > ax;
      num  = sw ? ax : ay;
      den0 = sw ? ay : ax;
   end
   // remainder stays below den <= 2^(IN_W-1), so the shift never loses a bit
   always_comb begin
      for (int s = 0; s < STG; s++) begin
         rem2[s] = rem[s] << 1;
         ge[s]   = rem2[s] >= {1'b0, den[s]};
      end
   end
   always_ff @(posedge clk) begin
      vld     <= rst ? '0 : {vld[STG-1:0], bus.val_i};
      rem[0]  <= {1'b0, num};
      den[0]  <= den0;
      q[0]    <= '0;
      side[0] <= {bus.x_i[IN_W-1], bus.y_i[IN_W-1], sw, den0 == '0};
      for (int s = 0; s < STG - 1; s++) begin
         rem[s+1] <= ge[s] ? rem2[s] - {1'b0, den[s]} : rem2[s];
         den[s+1] <= den[s];
      end
      for (int s = 0; s < STG; s++) begin
         q[s+1]    <= q[s] | (STG'(ge[s]) << (STG - 1 - s));
         side[s+1] <= side[s];
      end
   end
`ifdef ATAN_RATIO_ROUND_EN
   logic [FRAC_W:0] rnd;
   always_comb begin
      rnd     = {1'b0, q[STG][STG-1:1]} + (FRAC_W+1)'(q[STG][0]);
      ratio_n = rnd[FRAC_W] ? '1 : rnd[FRAC_W-1:0];
   end
`else
   always_comb ratio_n = q[STG];
`endif
   // num==den already restores to all ones; zero inputs restore to all ones too and must be forced
   always_ff @(posedge clk) begin
      bus.val_o   <= rst ? 1'b0 : vld[STG];
      bus.ratio_o <= (rst || side[STG][0]) ? '0 : ratio_n;
      bus.oct_o   <= rst ? 3'b000 : side[STG][3:1];
      bus.zero_o  <= rst ? 1'b0 : side[STG][0];
   end
endmodule

// File: tb/tb_atan_ratio_div.sv
// tb_atan_ratio_div: directed and streamed checks of atan_ratio_div against a queue-based reference.
module tb_atan_ratio_div;
`ifdef ATAN_RATIO_ROUND_EN
   localparam int LAT = 11;
   localparam logic [7:0] R32 = 8'd171;
`else
   localparam int LAT = 10;
   localparam logic [7:0] R32 = 8'd170;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   atan_ratio_div_if bus ();
   atan_ratio_div dut (.clk(clk), .rst(rst), .bus(bus));
   int vectors = 0;
   int errs = 0;
   bit chk_en = 1'b0;
   logic [11:0] sb[$];
   logic [LAT-1:0] pipe;
   function automatic logic [11:0] model(input logic signed [15:0] x, input logic signed [15:0] y);
      int ax, ay, num, den, q;
      logic sw;
      ax = (x < 0) ? -int'(x) : int'(x);
      ay = (y < 0) ? -int'(y) : int'(y);
      sw = ay > ax;
      num = sw ? ax : ay;
      den = sw ? ay : ax;
      if (den == 0) return {8'd0, x < 0, y < 0, sw, 1'b1};
`ifdef ATAN_RATIO_ROUND_EN
      q = ((num * 512) / den + 1) >> 1;
`else
      q = (num * 256) / den;
`endif
      if (q > 255) q = 255;
      return {q[7:0], x < 0, y < 0, sw, 1'b0};
   endfunction
   always @(posedge clk) begin
      pipe <= rst ? '0 : {pipe[LAT-2:0], bus.val_i};
      if (rst) sb.delete();
      else if (bus.val_i) sb.push_back(model(bus.x_i, bus.y_i));
   end
   always @(negedge clk) begin
      if (chk_en) begin
         logic [11:0] e;
         vectors++;
         if (bus.val_o !== pipe[LAT-1]) begin
            errs++;
            $display("FAIL val_align: val_o=%b expected %b at %0t", bus.val_o, pipe[LAT-1], $time);
         end
         if (bus.val_o === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
               errs++;
               $display("FAIL sb_empty: output with no expected entry at %0t", $time);
            end else begin
               e = sb.pop_front();
               if ({bus.ratio_o, bus.oct_o, bus.zero_o} !== e) begin
                  errs++;
                  $display("FAIL data: ratio=%0d oct=%b zero=%b expected ratio=%0d oct=%b zero=%b",
                           bus.ratio_o, bus.oct_o, bus.zero_o, e[11:4], e[3:1], e[0]);
               end
            end
         end
      end
   end
   task automatic check_one(input logic signed [15:0] x, input logic signed [15:0] y,
                            input logic [7:0] er, input logic [2:0] eo, input logic ez, input string nm);
      bus.val_i = 1'b1;
      bus.x_i = x;
      bus.y_i = y;
      @(posedge clk);
      #1 bus.val_i = 1'b0;
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.val_o, bus.ratio_o, bus.oct_o, bus.zero_o} !== {1'b1, er, eo, ez}) begin
         errs++;
         $display("FAIL %s: val=%b ratio=%0d oct=%b zero=%b expected val=1 ratio=%0d oct=%b zero=%b",
                  nm, bus.val_o, bus.ratio_o, bus.oct_o, bus.zero_o, er, eo, ez);
      end
      @(negedge clk);
      vectors++;
      if (bus.val_o !== 1'b0) begin
         errs++;
         $display("FAIL %s_pulse: val_o=%b expected 0", nm, bus.val_o);
      end
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      bus.val_i = 1'b1;
      bus.x_i = 16'sd5;
      bus.y_i = 16'sd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.val_o, bus.ratio_o, bus.oct_o, bus.zero_o} !== 13'd0) begin
         errs++;
         $display("FAIL reset: val=%b ratio=%0d oct=%b zero=%b expected all 0",
                  bus.val_o, bus.ratio_o, bus.oct_o, bus.zero_o);
      end
      bus.val_i = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
   endtask
   task automatic test_basic;
      check_one(16'sd100, 16'sd50, 8'd128, 3'b000, 1'b0, "basic");
   endtask
   task automatic test_swap_sign;
      check_one(-16'sd30, 16'sd90, 8'd85, 3'b101, 1'b0, "swap_sign");
      check_one(16'sd3, 16'sd2, R32, 3'b000, 1'b0, "round_3_2");
   endtask
   task automatic test_extremes;
      check_one(16'sd1000, 16'sd1000, 8'd255, 3'b000, 1'b0, "sat_tie");
      check_one(-16'sd32768, -16'sd32768, 8'd255, 3'b110, 1'b0, "sat_min");
      check_one(16'sd32767, 16'sd1, 8'd0, 3'b000, 1'b0, "tiny_ratio");
   endtask
   task automatic test_zero;
      check_one(16'sd0, 16'sd0, 8'd0, 3'b000, 1'b1, "zero");
   endtask
   task automatic test_stream;
      logic [5:0] gaps;
      gaps = 6'b100110;
      for (int i = 0; i < 1024; i++) begin
         bus.val_i = 1'b1;
         bus.x_i = 16'($urandom);
         bus.y_i = (i % 16 == 0) ? bus.x_i : (i % 16 == 1) ? -bus.x_i : 16'($urandom);
         if (i % 97 == 0) bus.x_i = -16'sd32768;
         @(posedge clk);
         #1;
      end
      for (int r = 0; r < 4; r++)
         for (int k = 5; k >= 0; k--) begin
            bus.val_i = gaps[k];
            bus.x_i = 16'($urandom);
            bus.y_i = 16'($urandom);
            @(posedge clk);
            #1;
         end
      bus.val_i = 1'b0;
      repeat (LAT + 2) @(posedge clk);
      #1;
      vectors++;
      if (sb.size() != 0) begin
         errs++;
         $display("FAIL stream_drain: %0d outputs missing, expected 0", sb.size());
      end
   endtask
   task automatic test_reset_mid;
      int n;
      for (int i = 0; i < 5; i++) begin
         bus.val_i = 1'b1;
         bus.x_i = 16'sd200 + 16'(i);
         bus.y_i = -16'sd77;
         @(posedge clk);
         #1;
      end
      bus.val_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.val_o !== 1'b0) begin
         errs++;
         $display("FAIL reset_mid: val_o=%b expected 0 after reset", bus.val_o);
      end
      repeat (LAT + 2) @(posedge clk);
      #1;
      bus.val_i = 1'b1;
      bus.x_i = 16'sd7;
      bus.y_i = 16'sd9;
      @(posedge clk);
      #1 bus.val_i = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (bus.val_o !== 1'b1 && n < 2 * LAT);
      vectors++;
      if (n + 1 != LAT) begin
         errs++;
         $display("FAIL reset_mid_latency: first output after %0d cycles, expected %0d", n + 1, LAT);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask
   initial begin
      bus.val_i = 1'b0;
      bus.x_i = '0;
      bus.y_i = '0;
      test_reset();
      test_basic();
      test_swap_sign();
      test_extremes();
      test_zero();
      test_stream();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
